// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose:
//   FSM controller for the multicycle RV32I core. It steps each instruction
//   through fetch, decode, execute and writeback. It stalls on the shared
//   memory's ready handshake, resolves all six conditional branches from the
//   ALU flags, and decodes the RV32I ALU operations. Unsupported opcodes and
//   funct3 values park the controller in TRAP until reset.
//
// Ports:
//   clk           : clock, rising edge
//   reset_n       : asynchronous reset, active-low
//   op            : instruction[6:0] from the IR
//   funct3        : instruction[14:12]
//   funct7_5      : instruction[30]
//   zero/lt/ltu   : ALU flags (equal, signed less-than, unsigned less-than)
//   mem_ready     : memory completes the current access this cycle
//   mem_req       : memory access request, held until mem_ready
//   adr_src       : 0 = PC address, 1 = alu_out address
//   ir_write      : load IR / old_pc
//   pc_write      : load PC from the result bus
//   mem_write     : store enable, qualified by mem_req
//   reg_write     : register file write
//   result_src    : 00 alu_out, 01 read data, 10 ALU result direct
//   alu_src_a     : 00 PC, 01 old_pc, 10 rs1, 11 zero
//   alu_src_b     : 00 rs2, 01 immediate, 10 constant 4
//   imm_src       : 000 I, 001 S, 010 B, 011 J, 100 U
//   alu_control   : ALU operation (ADD=0 SUB=1 SLT=2 SLTU=3 XOR=4 OR=5
//                   AND=6 SLL=7 SRL=8 SRA=9)
//   illegal_instr : high in TRAP; stays high until reset
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int ALU_CTRL_W    = 5,
   parameter bit SUPPORT_UPPER = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7_5,
   input  logic                  zero,
   input  logic                  lt,
   input  logic                  ltu,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  adr_src,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  mem_write,
   output logic                  reg_write,
   output logic [1:0]            result_src,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [2:0]            imm_src,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal_instr
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR_ADR = 4'd11;
   localparam logic [3:0] S_JALR     = 4'd12;
   localparam logic [3:0] S_LUI      = 4'd13;
   localparam logic [3:0] S_AUIPC    = 4'd14;
   localparam logic [3:0] S_TRAP     = 4'd15;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(5);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(6);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(7);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(8);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(9);

   logic [3:0]            state_q, state_d;
   logic                  branch_taken;
   logic                  branch_legal;
   logic [ALU_CTRL_W-1:0] alu_decoded;

   // Raw state decode; the write enables and mem_req are gated by reset below.
   logic mem_req_raw, ir_write_raw, pc_write_raw, mem_write_raw, reg_write_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // funct3 010/011 are not branch encodings.
   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:  branch_taken = zero;
         3'b001:  branch_taken = ~zero;
         3'b100:  branch_taken = lt;
         3'b101:  branch_taken = ~lt;
         3'b110:  branch_taken = ltu;
         3'b111:  branch_taken = ~ltu;
         default: branch_taken = 1'b0;
      endcase
   end

   assign branch_legal = (funct3[2:1] != 2'b01);

   // SUB exists only for register operands (op[5]=1). Immediate shifts use
   // funct7_5 to choose between SRL and SRA, just like register shifts.
   always_comb begin
      alu_decoded = ALU_ADD;
      case (funct3)
         3'b000:  alu_decoded = (funct7_5 & op[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_decoded = ALU_SLL;
         3'b010:  alu_decoded = ALU_SLT;
         3'b011:  alu_decoded = ALU_SLTU;
         3'b100:  alu_decoded = ALU_XOR;
         3'b101:  alu_decoded = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_decoded = ALU_OR;
         default: alu_decoded = ALU_AND;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mem_req_raw   = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      adr_src       = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      imm_src       = 3'b000;
      alu_control   = ALU_ADD;
      illegal_instr = 1'b0;

      case (state_q)
         S_FETCH: begin
            // PC+4 goes straight to the PC while the instruction is read.
            mem_req_raw = 1'b1;
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            // Precompute the branch/jump target into alu_out.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = (op == OP_JAL) ? 3'b011 : 3'b010;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_REG:            state_d = S_EXECR;
               OP_IMM:            state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = SUPPORT_UPPER ? S_JALR_ADR : S_TRAP;
               OP_LUI:            state_d = SUPPORT_UPPER ? S_LUI : S_TRAP;
               OP_AUIPC:          state_d = SUPPORT_UPPER ? S_AUIPC : S_TRAP;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            // op[5] separates store (0100011) from load (0000011).
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = op[5] ? 3'b001 : 3'b000;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req_raw = 1'b1;
            adr_src     = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_raw   = 1'b1;
            mem_write_raw = 1'b1;
            adr_src       = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_decoded;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_decoded;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            // The ALU compares rs1/rs2 while alu_out still holds the target.
            alu_src_a    = 2'b10;
            alu_control  = ALU_SUB;
            pc_write_raw = branch_taken & branch_legal;
            state_d      = branch_legal ? S_FETCH : S_TRAP;
         end
         S_JAL, S_JALR: begin
            // The PC takes the target from alu_out while the ALU forms
            // old_pc+4 for the link register.
            alu_src_a    = 2'b01;
            alu_src_b    = 2'b10;
            pc_write_raw = 1'b1;
            state_d      = S_ALUWB;
         end
         S_JALR_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = S_JALR;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            imm_src   = 3'b100;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 3'b100;
            state_d   = S_ALUWB;
         end
         default: begin
            // TRAP: absorbing until reset.
            illegal_instr = 1'b1;
         end
      endcase
   end

   // Reset drops every write and the memory request at once, without
   // waiting for a clock edge.
   assign mem_req   = mem_req_raw   & reset_n;
   assign ir_write  = ir_write_raw  & reset_n;
   assign pc_write  = pc_write_raw  & reset_n;
   assign mem_write = mem_write_raw & reset_n;
   assign reg_write = reg_write_raw & reset_n;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for multicycle_control_unit. Each step drives inputs on the
// falling edge, then compares the packed output word 1 ns later against a
// hand-written expected word. A second instance with SUPPORT_UPPER=0 shares
// the same inputs and is checked in the JALR scenario.
// Output word order: {mem_req, adr_src, ir_write, pc_write, mem_write,
// reg_write, result_src, alu_src_a, alu_src_b, imm_src, alu_control,
// illegal_instr}.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // Expected output words, one per state.
   localparam logic [20:0] F1    = {6'b101100, 2'b10, 2'b00, 2'b10, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] F0    = {6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] DEC   = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 5'd0, 1'b0};
   localparam logic [20:0] DEC_J = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b011, 5'd0, 1'b0};
   localparam logic [20:0] EXR   = {6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] EXI   = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] WB    = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] MA_L  = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] MA_S  = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 5'd0, 1'b0};
   localparam logic [20:0] MRD   = {6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] MWB   = {6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] MWR   = {6'b110010, 2'b00, 2'b00, 2'b00, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] BR_T  = {6'b000100, 2'b00, 2'b10, 2'b00, 3'b000, 5'd1, 1'b0};
   localparam logic [20:0] BR_N  = {6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 5'd1, 1'b0};
   localparam logic [20:0] JRA   = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] JMP   = {6'b000100, 2'b00, 2'b01, 2'b10, 3'b000, 5'd0, 1'b0};
   localparam logic [20:0] LUI   = {6'b000000, 2'b00, 2'b11, 2'b01, 3'b100, 5'd0, 1'b0};
   localparam logic [20:0] AUIPC = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b100, 5'd0, 1'b0};
   localparam logic [20:0] TRAP  = {20'd0, 1'b1};

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f75;
      logic        z;
      logic        lt;
      logic        ltu;
      logic        rdy;
      logic [20:0] ex;
   } step_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_5, zero, lt, ltu, mem_ready;

   logic       mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, illegal_instr;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src;
   logic [4:0] alu_control;

   logic       mem_req2, adr_src2, ir_write2, pc_write2, mem_write2, reg_write2, illegal_instr2;
   logic [1:0] result_src2, alu_src_a2, alu_src_b2;
   logic [2:0] imm_src2;
   logic [4:0] alu_control2;

   logic [20:0] outs, outs2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign outs  = {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
                   result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
   assign outs2 = {mem_req2, adr_src2, ir_write2, pc_write2, mem_write2, reg_write2,
                   result_src2, alu_src_a2, alu_src_b2, imm_src2, alu_control2, illegal_instr2};

   multicycle_control_unit #(.ALU_CTRL_W(5), .SUPPORT_UPPER(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
      .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_control(alu_control), .illegal_instr(illegal_instr)
   );

   multicycle_control_unit #(.ALU_CTRL_W(5), .SUPPORT_UPPER(1'b0)) dut_noupper (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .mem_req(mem_req2), .adr_src(adr_src2), .ir_write(ir_write2), .pc_write(pc_write2),
      .mem_write(mem_write2), .reg_write(reg_write2), .result_src(result_src2),
      .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .imm_src(imm_src2),
      .alu_control(alu_control2), .illegal_instr(illegal_instr2)
   );

   // Drive one cycle's inputs on the falling edge and settle before sampling.
   task automatic drive(input step_t st);
      @(negedge clk);
      op        = st.op;
      funct3    = st.f3;
      funct7_5  = st.f75;
      zero      = st.z;
      lt        = st.lt;
      ltu       = st.ltu;
      mem_ready = st.rdy;
      #1;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n   = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; mem_ready = 1'b1; op = OP_R; funct3 = 3'b000;
      funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_tests++;
      if ({mem_req, ir_write, pc_write, mem_write, reg_write, illegal_instr} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_gating: got %b want 000000",
                  {mem_req, ir_write, pc_write, mem_write, reg_write, illegal_instr});
      end
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_tests++;
      if (outs !== F0) begin
         n_fail++;
         $display("FAIL reset_fetch: got %b want %b", outs, F0);
      end
      $display("[TB] reset: released into FETCH");
   endtask

   task automatic test_add();
      step_t s [8];
      s = '{'{OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EXR},
            '{OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB},
            '{OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EXR | 21'd2},
            '{OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB}};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL add_sub step %0d: got %b want %b", i, outs, s[i].ex);
         end
      end
      $display("[TB] add then sub: 4 cycles each");
   endtask

   task automatic test_itype();
      step_t s [16];
      s = '{'{OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EXI | 21'd18},
            '{OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB},
            '{OP_I, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_I, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_I, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EXI | 21'd14},
            '{OP_I, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB},
            '{OP_I, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_I, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_I, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EXI | 21'd6},
            '{OP_I, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB},
            '{OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EXI},
            '{OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB}};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL itype step %0d: got %b want %b", i, outs, s[i].ex);
         end
      end
      $display("[TB] itype: srai=9 slli=7 sltiu=3 addi=0");
   endtask

   task automatic test_lw_stall();
      step_t s [8];
      s = '{'{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MA_L},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MRD},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MRD},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MRD},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MRD},
            '{OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MWB}};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL lw_stall step %0d: got %b want %b", i, outs, s[i].ex);
         end
      end
      $display("[TB] lw with 3 stall cycles: 8 cycles");
   endtask

   task automatic test_branch();
      step_t s [17];
      s = '{'{OP_BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BR_T},
            '{OP_BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, F1},
            '{OP_BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BR_N},
            '{OP_BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, F1},
            '{OP_BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DEC},
            '{OP_BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BR_T},
            '{OP_BR, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, F1},
            '{OP_BR, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DEC},
            '{OP_BR, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, BR_N},
            '{OP_BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, F1},
            '{OP_BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, DEC},
            '{OP_BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BR_N},
            '{OP_BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, TRAP},
            '{OP_R,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TRAP}};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL branch step %0d: got %b want %b", i, outs, s[i].ex);
         end
      end
      @(negedge clk);
      reset_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_tests++;
      if (illegal_instr !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_clear: got %b want 0", illegal_instr);
      end
      @(negedge clk);
      reset_n = 1'b1;
      $display("[TB] branches bne/bne/blt/bgeu then f3=010 trap cleared by reset");
   endtask

   task automatic test_jalr();
      step_t       s  [5];
      logic [20:0] e2 [5];
      s = '{'{OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, JRA},
            '{OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, JMP},
            '{OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB}};
      e2 = '{F1, DEC, TRAP, TRAP, TRAP};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL jalr step %0d: got %b want %b", i, outs, s[i].ex);
         end
         n_tests++;
         if (outs2 !== e2[i]) begin
            n_fail++;
            $display("FAIL jalr_noupper step %0d: got %b want %b", i, outs2, e2[i]);
         end
      end
      hold_reset();
      $display("[TB] jalr: 5 cycles; without upper support it traps");
   endtask

   task automatic test_back_to_back();
      step_t s [13];
      s = '{'{OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F0},
            '{OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, LUI},
            '{OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB},
            '{OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AUIPC},
            '{OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB},
            '{OP_JAL,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_JAL,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC_J},
            '{OP_JAL,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, JMP},
            '{OP_JAL,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB}};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b want %b", i, outs, s[i].ex);
         end
      end
      $display("[TB] back-to-back lui/auipc/jal after one fetch stall");
   endtask

   task automatic test_store_reset();
      step_t s [5];
      step_t t [3];
      s = '{'{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC},
            '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MA_S},
            '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MWR},
            '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MWR}};
      t = '{'{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F0},
            '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F1},
            '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEC}};
      foreach (s[i]) begin
         drive(s[i]);
         n_tests++;
         if (outs !== s[i].ex) begin
            n_fail++;
            $display("FAIL store step %0d: got %b want %b", i, outs, s[i].ex);
         end
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({mem_req, mem_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL store_abort: got %b want 00", {mem_req, mem_write});
      end
      @(negedge clk);
      reset_n = 1'b1;
      foreach (t[i]) begin
         drive(t[i]);
         n_tests++;
         if (outs !== t[i].ex) begin
            n_fail++;
            $display("FAIL store_restart step %0d: got %b want %b", i, outs, t[i].ex);
         end
      end
      $display("[TB] sw abandoned by reset, refetch without store");
   endtask

   initial begin
      test_reset();
      test_add();
      test_itype();
      test_lw_stall();
      test_branch();
      test_jalr();
      test_back_to_back();
      test_store_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
FSM-based control unit for the multicycle RV32I core; successor to the single-cycle decoder. Sequences fetch/decode/execute/writeback over several cycles and stalls on a memory ready handshake. Resolves the full branch set from ALU flags and decodes the complete RV32I ALU op set. Sits between the instruction register/flags and the shared-memory multicycle datapath.

Parameters:
ALU_CTRL_W, 5, alu_control width; encodings ADD=0 SUB=1 SLT=2 SLTU=3 XOR=4 OR=5 AND=6 SLL=7 SRL=8 SRA=9
SUPPORT_UPPER, 1, 1 enables LUI/AUIPC/JALR; 0 sends those opcodes to TRAP

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous reset, active-low
op  in  7  instruction[6:0] from IR
funct3  in  3  instruction[14:12]
funct7_5  in  1  instruction[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request, held until mem_ready
adr_src  out  1  0 = PC address, 1 = alu_out address
ir_write  out  1  load IR/old_pc
pc_write  out  1  load PC from result bus
mem_write  out  1  store enable, valid with mem_req
reg_write  out  1  register file write
result_src  out  2  00 alu_out, 01 read data, 10 ALU result direct
alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
alu_control  out  ALU_CTRL_W  ALU operation
illegal_instr  out  1  high in TRAP, sticky

Behaviour:
- Moore outputs decoded from state (alu_control/imm_src also from op/funct fields). Unlisted outputs 0; all write enables and mem_req forced 0 while reset_n=0. Reset (async) -> FETCH; reset mid-access abandons it, no write issued.
- FETCH: mem_req, adr_src=0, a=00, b=10, ADD, result_src=10. mem_ready=1: ir_write=1, pc_write=1, -> DECODE; else hold, no writes.
- DECODE: a=01, b=01, ADD, imm_src=011 if op=JAL else 010. Next: LW/SW->MEMADR, R->EXECR, I-ALU->EXECI, BRANCH->BRANCH, JAL->JAL, JALR->JALR_ADR, LUI->LUI, AUIPC->AUIPC; anything else -> TRAP.
- MEMADR: a=10, b=01, ADD, imm I (lw) / S (sw); -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req, adr_src=1; mem_ready -> MEMWB. MEMWB: result_src=01, reg_write -> FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1; held until mem_ready -> FETCH.
- EXECR: a=10, b=00; EXECI: a=10, b=01, imm I; both -> ALUWB. ALUWB: result_src=00, reg_write -> FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00; pc_write=taken; -> FETCH. taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 -> TRAP (no pc_write).
- JAL: a=01, b=10, ADD, result_src=00, pc_write -> ALUWB (rd=old_pc+4).
- JALR_ADR: a=10, b=01, imm I, ADD -> JALR; JALR: same outputs as JAL -> ALUWB.
- LUI: a=11, b=01, imm U, ADD; AUIPC: a=01, b=01, imm U, ADD; both -> ALUWB.
- TRAP: illegal_instr=1, no writes, no mem_req; leaves only on reset.
- ALU decode (EXECR/EXECI): funct3 000 SUB if funct7_5&op[5] else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7_5 else SRL (both types); 110 OR; 111 AND.
- Latency with mem_ready=1: R/I/LUI/AUIPC/JAL 4 cycles, LW 5, SW 4, branch 3, JALR 5. Each mem_ready-low cycle adds one.

Test Plan:
- Reset, add (op 0110011, f3 000, f7_5 0), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; alu_control=0; reg_write one cycle in cycle 4; f7_5=1 -> alu_control=1.
- lw, mem_ready low 3 cycles in MEMREAD -> mem_req=1, adr_src=1 for 4 cycles, reg_write only in MEMWB, total 8 cycles.
- bne (f3 001): zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0; f3 010 -> TRAP, illegal_instr stays 1 until reset_n=0.
- I-type 0010011: f3 101 f7_5 1 -> 9; f3 001 -> 7; f3 011 -> 3; f3 000 f7_5 1 -> 0 (no SUB).
- jalr: FETCH,DECODE,JALR_ADR,JALR,ALUWB, pc_write only in FETCH and JALR; SUPPORT_UPPER=0 -> TRAP after DECODE.
- reset_n low in MEMWRITE with mem_ready=0 -> mem_req/mem_write drop immediately; after release, FETCH, no store issued.
